// File: rtl/reorder_buffer.sv
// In-order dual-allocate / dual-retire reorder buffer sitting behind the rename stage.
// Optional flush input: define ROB_FLUSH_EN to add flush_i (clears all entries like en_flag_i=0).
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 6,
    parameter int AREG_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_flag_i,
`ifdef ROB_FLUSH_EN
    input  logic                       flush_i,
`endif
    input  logic                       alloc_v_1,
    input  logic [AREG_W-1:0]          rd_1,
    input  logic [PREG_W-1:0]          pd_1,
    input  logic [PREG_W-1:0]          old_pd_1,
    input  logic                       alloc_v_2,
    input  logic [AREG_W-1:0]          rd_2,
    input  logic [PREG_W-1:0]          pd_2,
    input  logic [PREG_W-1:0]          old_pd_2,
    output logic                       alloc_rdy,
    output logic [$clog2(DEPTH)-1:0]   rob_idx_1,
    output logic [$clog2(DEPTH)-1:0]   rob_idx_2,
    input  logic                       cmp_v_1,
    input  logic [$clog2(DEPTH)-1:0]   cmp_idx_1,
    input  logic                       cmp_v_2,
    input  logic [$clog2(DEPTH)-1:0]   cmp_idx_2,
    output logic                       rt_flag_1,
    output logic [PREG_W-1:0]          fp_i_1,
    output logic                       rt_flag_2,
    output logic [PREG_W-1:0]          fp_i_2,
    output logic                       cm_v_1,
    output logic [AREG_W-1:0]          cm_rd_1,
    output logic [PREG_W-1:0]          cm_pd_1,
    output logic                       cm_v_2,
    output logic [AREG_W-1:0]          cm_rd_2,
    output logic [PREG_W-1:0]          cm_pd_2,
    output logic                       rob_empty
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - 2);

    logic [DEPTH-1:0]  valid_q, done_q, valid_nx, done_nx;
    logic [AREG_W-1:0] rd_q   [DEPTH];
    logic [PREG_W-1:0] pd_q   [DEPTH];
    logic [PREG_W-1:0] opd_q  [DEPTH];
    logic [IW-1:0]     head_q, tail_q, head_nx, tail_nx, head_p1;
    logic [CW-1:0]     count_q, count_nx;
    logic              clr, acc1, acc2, ret1, ret2, sel1, sel2;

`ifdef ROB_FLUSH_EN
    assign clr = !en_flag_i || flush_i;
`else
    assign clr = !en_flag_i;
`endif

    // Readiness looks only at the registered count; same-cycle retires are not credited.
    assign alloc_rdy = (count_q <= RDY_MAX);
    assign rob_empty = (count_q == '0);
    assign rob_idx_1 = tail_q;
    assign rob_idx_2 = alloc_v_1 ? tail_q + IW'(1) : tail_q;
    assign acc1      = !clr && alloc_rdy && alloc_v_1;
    assign acc2      = !clr && alloc_rdy && alloc_v_2;

    assign head_p1 = head_q + IW'(1);
    assign ret1    = !clr && valid_q[head_q] && done_q[head_q];
    assign ret2    = ret1 && valid_q[head_p1] && done_q[head_p1];
    assign sel1    = ret1 && (rd_q[head_q] != '0);
    assign sel2    = ret2 && (rd_q[head_p1] != '0);

    always_comb begin
        valid_nx = valid_q;
        done_nx  = done_q;
        if (cmp_v_1 && valid_q[cmp_idx_1]) done_nx[cmp_idx_1] = 1'b1;
        if (cmp_v_2 && valid_q[cmp_idx_2]) done_nx[cmp_idx_2] = 1'b1;
        if (ret1) begin
            valid_nx[head_q] = 1'b0;
            done_nx[head_q]  = 1'b0;
        end
        if (ret2) begin
            valid_nx[head_p1] = 1'b0;
            done_nx[head_p1]  = 1'b0;
        end
        if (acc1) begin
            valid_nx[tail_q] = 1'b1;
            done_nx[tail_q]  = 1'b0;
        end
        if (acc2) begin
            valid_nx[rob_idx_2] = 1'b1;
            done_nx[rob_idx_2]  = 1'b0;
        end
        head_nx  = head_q + IW'(ret1) + IW'(ret2);
        tail_nx  = tail_q + IW'(acc1) + IW'(acc2);
        count_nx = count_q + CW'(acc1) + CW'(acc2) - CW'(ret1) - CW'(ret2);
        // Pipeline disable / flush wipes the whole buffer, overriding everything above.
        if (clr) begin
            valid_nx = '0;
            done_nx  = '0;
            head_nx  = '0;
            tail_nx  = '0;
            count_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            done_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rt_flag_1 <= 1'b0;
            fp_i_1    <= '0;
            rt_flag_2 <= 1'b0;
            fp_i_2    <= '0;
            cm_v_1    <= 1'b0;
            cm_rd_1   <= '0;
            cm_pd_1   <= '0;
            cm_v_2    <= 1'b0;
            cm_rd_2   <= '0;
            cm_pd_2   <= '0;
        end else begin
            valid_q   <= valid_nx;
            done_q    <= done_nx;
            head_q    <= head_nx;
            tail_q    <= tail_nx;
            count_q   <= count_nx;
            rt_flag_1 <= sel1;
            fp_i_1    <= sel1 ? opd_q[head_q] : '0;
            cm_v_1    <= sel1;
            cm_rd_1   <= sel1 ? rd_q[head_q] : '0;
            cm_pd_1   <= sel1 ? pd_q[head_q] : '0;
            rt_flag_2 <= sel2;
            fp_i_2    <= sel2 ? opd_q[head_p1] : '0;
            cm_v_2    <= sel2;
            cm_rd_2   <= sel2 ? rd_q[head_p1] : '0;
            cm_pd_2   <= sel2 ? pd_q[head_p1] : '0;
        end
    end

    // Payload storage needs no reset; valid_q qualifies every read.
    always_ff @(posedge clk) begin
        if (acc1) begin
            rd_q[tail_q]  <= rd_1;
            pd_q[tail_q]  <= pd_1;
            opd_q[tail_q] <= old_pd_1;
        end
        if (acc2) begin
            rd_q[rob_idx_2]  <= rd_2;
            pd_q[rob_idx_2]  <= pd_2;
            opd_q[rob_idx_2] <= old_pd_2;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue-based program-order model checked every
// cycle on the falling edge, plus literal expectations at key points.
module tb_reorder_buffer;
    localparam int D = 16;

    logic       clk, rst_n, en_flag_i;
    logic       alloc_v_1, alloc_v_2, cmp_v_1, cmp_v_2;
    logic [4:0] rd_1, rd_2;
    logic [5:0] pd_1, old_pd_1, pd_2, old_pd_2;
    logic [3:0] cmp_idx_1, cmp_idx_2, rob_idx_1, rob_idx_2;
    logic       alloc_rdy, rob_empty, rt_flag_1, rt_flag_2, cm_v_1, cm_v_2;
    logic [5:0] fp_i_1, fp_i_2, cm_pd_1, cm_pd_2;
    logic [4:0] cm_rd_1, cm_rd_2;
`ifdef ROB_FLUSH_EN
    logic       flush_i = 1'b0;
`endif

    reorder_buffer #(.DEPTH(D), .PREG_W(6), .AREG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .en_flag_i(en_flag_i),
`ifdef ROB_FLUSH_EN
        .flush_i(flush_i),
`endif
        .alloc_v_1(alloc_v_1), .rd_1(rd_1), .pd_1(pd_1), .old_pd_1(old_pd_1),
        .alloc_v_2(alloc_v_2), .rd_2(rd_2), .pd_2(pd_2), .old_pd_2(old_pd_2),
        .alloc_rdy(alloc_rdy), .rob_idx_1(rob_idx_1), .rob_idx_2(rob_idx_2),
        .cmp_v_1(cmp_v_1), .cmp_idx_1(cmp_idx_1), .cmp_v_2(cmp_v_2), .cmp_idx_2(cmp_idx_2),
        .rt_flag_1(rt_flag_1), .fp_i_1(fp_i_1), .rt_flag_2(rt_flag_2), .fp_i_2(fp_i_2),
        .cm_v_1(cm_v_1), .cm_rd_1(cm_rd_1), .cm_pd_1(cm_pd_1),
        .cm_v_2(cm_v_2), .cm_rd_2(cm_rd_2), .cm_pd_2(cm_pd_2),
        .rob_empty(rob_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int idx; int rd; int pd; int opd; bit done; } ent_t;
    ent_t q[$];
    int   tail_m = 0;
    int   e_rt[2], e_fp[2], e_cmv[2], e_rd[2], e_pd[2];
    int   n_cmp = 0, n_fail = 0;
    bit   cap_en = 0;
    int   got[$], want[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic clr_out();
        for (int s = 0; s < 2; s++) begin
            e_rt[s] = 0; e_fp[s] = 0; e_cmv[s] = 0; e_rd[s] = 0; e_pd[s] = 0;
        end
    endtask

    task automatic retire_to(input int s, input ent_t e);
        if (e.rd != 0) begin
            e_rt[s] = 1; e_fp[s] = e.opd; e_cmv[s] = 1; e_rd[s] = e.rd; e_pd[s] = e.pd;
        end
    endtask

    // Program-order model: retire from the front of the queue, then mark completions,
    // then append accepted allocations.
    task automatic model_step();
        ent_t e;
        bit   rdy;
        if (!rst_n) return;
        clr_out();
        if (!en_flag_i) begin
            q.delete();
            tail_m = 0;
            return;
        end
        rdy = (D - q.size()) >= 2;
        if (q.size() > 0 && q[0].done) begin
            e = q.pop_front();
            retire_to(0, e);
            if (q.size() > 0 && q[0].done) begin
                e = q.pop_front();
                retire_to(1, e);
            end
        end
        for (int k = 0; k < q.size(); k++)
            if ((cmp_v_1 && int'(cmp_idx_1) == q[k].idx) || (cmp_v_2 && int'(cmp_idx_2) == q[k].idx)) begin
                e = q[k]; e.done = 1; q[k] = e;
            end
        if (rdy && alloc_v_1) begin
            e = '{tail_m, int'(rd_1), int'(pd_1), int'(old_pd_1), 1'b0};
            q.push_back(e);
            tail_m = (tail_m + 1) % D;
        end
        if (rdy && alloc_v_2) begin
            e = '{tail_m, int'(rd_2), int'(pd_2), int'(old_pd_2), 1'b0};
            q.push_back(e);
            tail_m = (tail_m + 1) % D;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        alloc_v_1 = 0; alloc_v_2 = 0; cmp_v_1 = 0; cmp_v_2 = 0;
    endtask

    task automatic set_a(input bit v1, input int r1, input int p1, input int o1,
                         input bit v2, input int r2, input int p2, input int o2);
        alloc_v_1 = v1; rd_1 = 5'(r1); pd_1 = 6'(p1); old_pd_1 = 6'(o1);
        alloc_v_2 = v2; rd_2 = 5'(r2); pd_2 = 6'(p2); old_pd_2 = 6'(o2);
    endtask

    task automatic set_c(input bit v1, input int i1, input bit v2, input int i2);
        cmp_v_1 = v1; cmp_idx_1 = 4'(i1 % D); cmp_v_2 = v2; cmp_idx_2 = 4'(i2 % D);
    endtask

    always @(negedge clk) begin
        chk("alloc_rdy", int'(alloc_rdy), int'((D - q.size()) >= 2));
        chk("rob_empty", int'(rob_empty), int'(q.size() == 0));
        chk("rob_idx_1", int'(rob_idx_1), tail_m);
        chk("rob_idx_2", int'(rob_idx_2), alloc_v_1 ? (tail_m + 1) % D : tail_m);
        chk("rt_flag_1", int'(rt_flag_1), e_rt[0]);
        chk("rt_flag_2", int'(rt_flag_2), e_rt[1]);
        chk("fp_i_1", int'(fp_i_1), e_fp[0]);
        chk("fp_i_2", int'(fp_i_2), e_fp[1]);
        chk("cm_v_1", int'(cm_v_1), e_cmv[0]);
        chk("cm_v_2", int'(cm_v_2), e_cmv[1]);
        chk("cm_rd_1", int'(cm_rd_1), e_rd[0]);
        chk("cm_rd_2", int'(cm_rd_2), e_rd[1]);
        chk("cm_pd_1", int'(cm_pd_1), e_pd[0]);
        chk("cm_pd_2", int'(cm_pd_2), e_pd[1]);
        if (cap_en) begin
            if (rt_flag_1) got.push_back(int'(fp_i_1));
            if (rt_flag_2) got.push_back(int'(fp_i_2));
        end
    end

    initial begin
        int a;
        clr_out();
        rst_n = 0; en_flag_i = 1;
        idle(); set_a(0, 0, 0, 0, 0, 0, 0, 0); set_c(0, 0, 0, 0);
        #2;
        chk("reset_empty", int'(rob_empty), 1);
        chk("reset_rdy", int'(alloc_rdy), 1);
        cyc(); cyc();
        #2 rst_n = 1;
        cyc();

        // Two entries, younger completes first; both retire together in order.
        set_a(1, 3, 33, 3, 1, 4, 34, 4); cyc();
        idle(); set_c(1, 1, 0, 0); cyc();
        set_c(1, 0, 0, 0); cyc();
        idle(); cyc();
        chk("t2_rt1", int'(rt_flag_1), 1);
        chk("t2_rt2", int'(rt_flag_2), 1);
        chk("t2_fp1", int'(fp_i_1), 3);
        chk("t2_fp2", int'(fp_i_2), 4);
        chk("t2_cmpd1", int'(cm_pd_1), 33);
        chk("t2_cmpd2", int'(cm_pd_2), 34);
        cyc();
        chk("t2_pulse", int'(rt_flag_1), 0);

        // Fill with single allocs; ready drops at 15 entries and extra requests are lost.
        got.delete(); cap_en = 1;
        for (int i = 0; i < 20; i++) begin
            set_a(1, i + 1, i, i + 40, 0, 0, 0, 0); cyc();
        end
        idle();
        chk("t3_full_rdy", int'(alloc_rdy), 0);
        for (int k = 0; k < D; k++) begin
            set_c(1, k, 1, k); cyc();
        end
        idle(); repeat (4) cyc();
        cap_en = 0;
        chk("t3_drained", int'(rob_empty), 1);
        chk("t3_retired", got.size(), 15);
        for (int i = 0; i < 15 && i < got.size(); i++) chk("t3_fp_seq", got[i], i + 40);

        // Entry without a destination retires silently.
        a = tail_m;
        set_a(1, 0, 10, 20, 1, 5, 11, 21); cyc();
        idle(); set_c(1, a, 0, 0); cyc();
        idle(); cyc();
        chk("t4_rt1", int'(rt_flag_1), 0);
        chk("t4_cmv1", int'(cm_v_1), 0);
        chk("t4_one_left", int'(rob_empty), 0);
        set_c(1, a + 1, 0, 0); cyc();
        idle(); repeat (3) cyc();
        chk("t4_empty", int'(rob_empty), 1);

        // 40 instructions in pairs, wrapping both pointers several times.
        got.delete(); want.delete(); cap_en = 1;
        for (int i = 0; i < 20; i++) begin
            a = tail_m;
            set_a(1, (2 * i) % 31 + 1, (2 * i) % 64, (2 * i + 7) % 64,
                  1, (2 * i + 1) % 31 + 1, (2 * i + 1) % 64, (2 * i + 8) % 64);
            want.push_back((2 * i + 7) % 64);
            want.push_back((2 * i + 8) % 64);
            cyc();
            idle();
            if (i % 2 == 0) begin
                set_c(1, a + 1, 1, a); cyc();
            end else begin
                set_c(1, a, 1, a); cyc();
                set_c(1, a + 1, 0, 0); cyc();
            end
        end
        idle(); repeat (4) cyc();
        cap_en = 0;
        chk("t5_count", got.size(), 40);
        for (int i = 0; i < 40 && i < got.size(); i++) chk("t5_fp_seq", got[i], want[i]);

        // Pipeline disable wipes five live entries; late completions must not retire them.
        a = tail_m;
        set_a(1, 1, 1, 2, 1, 2, 3, 4); cyc();
        set_a(1, 3, 5, 6, 1, 4, 7, 8); cyc();
        set_a(1, 5, 9, 10, 0, 0, 0, 0); cyc();
        idle(); en_flag_i = 0; cyc();
        en_flag_i = 1;
        chk("t6_empty", int'(rob_empty), 1);
        chk("t6_rdy", int'(alloc_rdy), 1);
        chk("t6_tail", int'(rob_idx_1), 0);
        got.delete(); cap_en = 1;
        for (int k = 0; k < 5; k++) begin
            set_c(1, a + k, 0, 0); cyc();
        end
        idle(); repeat (3) cyc();
        cap_en = 0;
        chk("t6_no_retire", got.size(), 0);

        // Asynchronous reset in the middle of a retire pulse.
        set_a(1, 7, 17, 27, 1, 8, 18, 28); cyc();
        idle(); set_c(1, 0, 1, 1); cyc();
        idle(); cyc();
        chk("t1_pre_rt", int'(rt_flag_1), 1);
        #2 rst_n = 0;
        q.delete(); tail_m = 0; clr_out();
        #1;
        chk("t1_rt1", int'(rt_flag_1), 0);
        chk("t1_fp1", int'(fp_i_1), 0);
        chk("t1_empty", int'(rob_empty), 1);
        chk("t1_rdy", int'(alloc_rdy), 1);
        #3 rst_n = 1;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
